multicycle_control_unit: RTL and testbench

- Multi-cycle control FSM for the single-issue datapath. Sequences fetch, decode, execute, memory and writeback around the 1-cycle-latency instruction and data BRAMs.
- Drives every datapath control input, plus PC and instruction-latch enables.
- Consumes the decoded opcode/func fields and maintains a retired-instruction counter.

---
 rtl/control_pkg.sv | 56 +++++
 rtl/control_decode.sv | 80 ++++++++
 rtl/multicycle_control_unit.sv | 158 +++++++++++++++
 tb/tb_multicycle_control_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared definitions for the multi-cycle control unit.
// Holds the opcode and ALU-operation constants, the FSM state enum, the
// retirement-sequence enum and the packed control word that the decoder
// hands to the sequencing FSM.
package control_pkg;

  // Opcode field values
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ITYPE = 6'd1;
  localparam logic [5:0] OP_LW    = 6'd2;
  localparam logic [5:0] OP_SW    = 6'd3;
  localparam logic [5:0] OP_BCC   = 6'd4;
  localparam logic [5:0] OP_B     = 6'd5;
  localparam logic [5:0] OP_BL    = 6'd6;
  localparam logic [5:0] OP_JR    = 6'd7;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // ALU operation codes the control unit generates on its own
  localparam logic [4:0] ALU_ADD  = 5'b00001;
  localparam logic [4:0] ALU_PASS = 5'b11111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IF,
    S_ID,
    S_EX,
    S_MEM,
    S_WB,
    S_HALTED
  } state_e;

  // Which states an instruction walks through after ID; the last one
  // listed is the retire state that carries pc_en.
  typedef enum logic [1:0] {
    SEQ_EX,
    SEQ_EX_WB,
    SEQ_EX_MEM,
    SEQ_EX_MEM_WB
  } seq_e;

  typedef struct packed {
    logic [1:0] regDst;
    logic [1:0] memToReg;
    logic [4:0] aluOp;
    logic       aluSrc;
    logic       aluSel;
    logic       lblSel;
    logic       jumpAddr;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       branch;
    seq_e       seq;
  } ctrl_word_t;

endpackage

// File: rtl/control_decode.sv
// Combinational instruction decoder.
// Maps a latched opcode/func pair to a control word, a halt flag and an
// illegal-opcode flag. Strobe bits in the word only say which strobes the
// instruction uses; the FSM decides in which cycle they fire.
// Ports:
//   opcode_i  6-bit opcode field
//   func_i    5-bit func field
//   ctrl_o    decoded control word
//   halt_o    opcode is HALT
//   illegal_o opcode is not recognised
module control_decode
  import control_pkg::*;
(
  input  logic [5:0]  opcode_i,
  input  logic [4:0]  func_i,
  output ctrl_word_t  ctrl_o,
  output logic        halt_o,
  output logic        illegal_o
);

  // Unknown opcodes fall through to an all-zero word with a single-state
  // sequence, which retires them as a NOP.
  always_comb begin
    ctrl_o    = '0;
    ctrl_o.seq = SEQ_EX;
    halt_o    = 1'b0;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_RTYPE, OP_ITYPE: begin
        ctrl_o.memToReg = 2'd2;
        ctrl_o.aluOp    = func_i;
        ctrl_o.aluSrc   = (opcode_i == OP_ITYPE);
        ctrl_o.aluSel   = (func_i[4:3] == 2'b11);
        ctrl_o.regWrite = 1'b1;
        ctrl_o.seq      = SEQ_EX_WB;
      end
      OP_LW: begin
        ctrl_o.regDst   = 2'd1;
        ctrl_o.memToReg = 2'd1;
        ctrl_o.aluSrc   = 1'b1;
        ctrl_o.aluOp    = ALU_ADD;
        ctrl_o.regWrite = 1'b1;
        ctrl_o.memRead  = 1'b1;
        ctrl_o.seq      = SEQ_EX_MEM_WB;
      end
      OP_SW: begin
        ctrl_o.aluSrc   = 1'b1;
        ctrl_o.aluOp    = ALU_ADD;
        ctrl_o.memWrite = 1'b1;
        ctrl_o.seq      = SEQ_EX_MEM;
      end
      OP_BCC: begin
        ctrl_o.branch   = 1'b1;
        ctrl_o.lblSel   = 1'b1;
        ctrl_o.aluOp    = ALU_PASS;
      end
      OP_B: begin
        ctrl_o.branch   = 1'b1;
      end
      OP_BL: begin
        ctrl_o.branch   = 1'b1;
        ctrl_o.regDst   = 2'd2;
        ctrl_o.memToReg = 2'd0;
        ctrl_o.regWrite = 1'b1;
        ctrl_o.seq      = SEQ_EX_WB;
      end
      OP_JR: begin
        ctrl_o.jumpAddr = 1'b1;
        ctrl_o.branch   = 1'b1;
      end
      OP_HALT: begin
        halt_o = 1'b1;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the single-issue datapath.
// Sequences IF/ID/EX/MEM/WB around 1-cycle-latency instruction and data
// BRAMs, drives every datapath control input and counts retired
// instructions. All outputs are registered: each is computed from the
// state being entered, so it is valid for the whole cycle of that state.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               leave IDLE and begin fetching
//   opcode, func        instruction fields, sampled at the end of ID
//   regDst..lblSel      control-word fields for the datapath
//   regWrite, memRead,
//   memWrite, branch    per-state strobes
//   pc_en, ir_en        PC load and instruction latch enables
//   busy, halted        FSM activity / HALT retired
//   illegal             sticky unknown-opcode flag
//   instr_count         retired-instruction counter (wraps)
module multicycle_control_unit
  import control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       opcode,
  input  logic [4:0]       func,
  output logic [1:0]       regDst,
  output logic             regWrite,
  output logic             memRead,
  output logic             memWrite,
  output logic [1:0]       memToReg,
  output logic [4:0]       ALUop,
  output logic             ALUsrc,
  output logic             ALUsel,
  output logic             branch,
  output logic             jumpAddr,
  output logic             lblSel,
  output logic             pc_en,
  output logic             ir_en,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_e     state_q, state_d;
  logic [5:0] opcode_q, opcode_d;
  logic [4:0] func_q, func_d;
  ctrl_word_t ctrl;
  logic       decHalt;
  logic       decIllegal;
  logic       inExec;
  logic       retire;

  // The instruction word is captured on the edge that leaves ID. The
  // decoder always looks at the value the latch will hold, so the word
  // registered into EX and held through WB never sees later input changes.
  always_comb begin
    opcode_d = opcode_q;
    func_d   = func_q;
    if (state_q == S_ID) begin
      opcode_d = opcode;
      func_d   = func;
    end
  end

  control_decode u_decode (
    .opcode_i  (opcode_d),
    .func_i    (func_d),
    .ctrl_o    (ctrl),
    .halt_o    (decHalt),
    .illegal_o (decIllegal)
  );

  // Next-state logic plus the retire condition of the state being entered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_IF;
      S_IF:     state_d = S_ID;
      S_ID:     state_d = decHalt ? S_HALTED : S_EX;
      S_EX: begin
        case (ctrl.seq)
          SEQ_EX:     state_d = S_IF;
          SEQ_EX_WB:  state_d = S_WB;
          default:    state_d = S_MEM;
        endcase
      end
      S_MEM:    state_d = (ctrl.seq == SEQ_EX_MEM_WB) ? S_WB : S_IF;
      S_WB:     state_d = S_IF;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase

    inExec = (state_d == S_EX) || (state_d == S_MEM) || (state_d == S_WB);
    retire = ((state_d == S_EX)  && (ctrl.seq == SEQ_EX))     ||
             ((state_d == S_MEM) && (ctrl.seq == SEQ_EX_MEM)) ||
             (state_d == S_WB);
  end

  // State, instruction latch and all registered outputs. Every strobe except
  // memRead fires only in the retire state, alongside pc_en; memRead covers
  // MEM and WB so the load data is still presented during writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      opcode_q    <= '0;
      func_q      <= '0;
      regDst      <= '0;
      regWrite    <= 1'b0;
      memRead     <= 1'b0;
      memWrite    <= 1'b0;
      memToReg    <= '0;
      ALUop       <= '0;
      ALUsrc      <= 1'b0;
      ALUsel      <= 1'b0;
      branch      <= 1'b0;
      jumpAddr    <= 1'b0;
      lblSel      <= 1'b0;
      pc_en       <= 1'b0;
      ir_en       <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      func_q   <= func_d;

      regDst   <= inExec ? ctrl.regDst   : 2'd0;
      memToReg <= inExec ? ctrl.memToReg : 2'd0;
      ALUop    <= inExec ? ctrl.aluOp    : 5'd0;
      ALUsrc   <= inExec && ctrl.aluSrc;
      ALUsel   <= inExec && ctrl.aluSel;
      lblSel   <= inExec && ctrl.lblSel;
      jumpAddr <= inExec && ctrl.jumpAddr;

      regWrite <= retire && ctrl.regWrite;
      memWrite <= retire && ctrl.memWrite;
      branch   <= retire && ctrl.branch;
      pc_en    <= retire;
      memRead  <= ctrl.memRead && ((state_d == S_MEM) || (state_d == S_WB));
      ir_en    <= (state_d == S_IF);

      busy     <= (state_d != S_IDLE) && (state_d != S_HALTED);
      halted   <= (state_d == S_HALTED);

      if ((state_q == S_ID) && decIllegal) begin
        illegal <= 1'b1;
      end
      if (retire) begin
        instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit.
// Drives directed and random instruction streams and compares every output
// every cycle against a reference built from per-class latencies and the
// cycle index within the instruction. A narrow counter is used so the
// instr_count wrap is exercised.
module tb_multicycle_control_unit;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [5:0]       opcode;
  logic [4:0]       func;
  logic [1:0]       regDst;
  logic             regWrite;
  logic             memRead;
  logic             memWrite;
  logic [1:0]       memToReg;
  logic [4:0]       ALUop;
  logic             ALUsrc;
  logic             ALUsel;
  logic             branch;
  logic             jumpAddr;
  logic             lblSel;
  logic             pc_en;
  logic             ir_en;
  logic             busy;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  int checks = 0;
  int errors = 0;

  // Reference-model state
  logic [CNT_W-1:0] modelCount;
  logic             modelIllegal;
  int               expLat;
  logic             expRegW, expMemW, expLoad, expBr, expIll;
  logic [1:0]       expRegDst, expMemToReg;
  logic [4:0]       expAluOp;
  logic             expAluSrc, expAluSel, expLbl, expJmp;

  multicycle_control_unit #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .opcode      (opcode),
    .func        (func),
    .regDst      (regDst),
    .regWrite    (regWrite),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .memToReg    (memToReg),
    .ALUop       (ALUop),
    .ALUsrc      (ALUsrc),
    .ALUsel      (ALUsel),
    .branch      (branch),
    .jumpAddr    (jumpAddr),
    .lblSel      (lblSel),
    .pc_en       (pc_en),
    .ir_en       (ir_en),
    .busy        (busy),
    .halted      (halted),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Advance one cycle and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count one comparison and report it when it does not match
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // All non-counter outputs in one fixed order
  function automatic logic [21:0] observed();
    return {regDst, memToReg, ALUop, ALUsrc, ALUsel, lblSel, jumpAddr,
            regWrite, memRead, memWrite, branch, pc_en, ir_en, busy, halted, illegal};
  endfunction

  // Expected outputs for an idle or halted cycle
  function automatic logic [21:0] quietVec(input logic isHalted, input logic ill);
    return {2'd0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, isHalted, ill};
  endfunction

  // Instruction-class table: latency, which strobes fire at retirement and
  // the control-word field values.
  task automatic modelDecode(input logic [5:0] op, input logic [4:0] fn);
    expLat = 3; expRegW = 0; expMemW = 0; expLoad = 0; expBr = 0; expIll = 0;
    expRegDst = 0; expMemToReg = 0; expAluOp = 0;
    expAluSrc = 0; expAluSel = 0; expLbl = 0; expJmp = 0;
    if (op == 6'd0 || op == 6'd1) begin
      expLat = 4; expRegW = 1; expMemToReg = 2; expAluOp = fn;
      expAluSrc = (op == 6'd1); expAluSel = (fn >= 5'd24);
    end else if (op == 6'd2) begin
      expLat = 5; expRegW = 1; expLoad = 1; expRegDst = 1; expMemToReg = 1;
      expAluSrc = 1; expAluOp = 5'd1;
    end else if (op == 6'd3) begin
      expLat = 4; expMemW = 1; expAluSrc = 1; expAluOp = 5'd1;
    end else if (op == 6'd4) begin
      expBr = 1; expLbl = 1; expAluOp = 5'd31;
    end else if (op == 6'd5) begin
      expBr = 1;
    end else if (op == 6'd6) begin
      expLat = 4; expBr = 1; expRegDst = 2; expRegW = 1;
    end else if (op == 6'd7) begin
      expBr = 1; expJmp = 1;
    end else begin
      expIll = 1;
    end
  endtask

  // Run one instruction starting in its fetch cycle. The instruction word is
  // only valid during the decode cycle; other cycles carry random junk.
  // With stopAt nonzero the run stops after checking that cycle, leaving the
  // clock un-advanced so the caller can intervene.
  task automatic applyStimulus(input logic [5:0] op, input logic [4:0] fn, input int stopAt);
    int last;
    logic [21:0] expVec;
    logic fOn;
    modelDecode(op, fn);
    last = (stopAt != 0) ? stopAt : expLat;
    for (int k = 1; k <= last; k++) begin
      fOn = (k >= 3);
      if (k == 3 && expIll) modelIllegal = 1'b1;
      if (k == expLat) modelCount = modelCount + 1'b1;
      expVec = {fOn ? expRegDst : 2'd0, fOn ? expMemToReg : 2'd0, fOn ? expAluOp : 5'd0,
                fOn & expAluSrc, fOn & expAluSel, fOn & expLbl, fOn & expJmp,
                (k == expLat) & expRegW, expLoad & (k >= 4), (k == expLat) & expMemW,
                (k == expLat) & expBr, (k == expLat), (k == 1), 1'b1, 1'b0, modelIllegal};
      checkOutput($sformatf("ctrl op%0d c%0d", op, k), 64'(observed()), 64'(expVec));
      checkOutput($sformatf("count op%0d c%0d", op, k), 64'(instr_count), 64'(modelCount));
      if (k == 2) begin
        opcode = op;
        func   = fn;
      end else begin
        opcode = 6'($urandom);
        func   = 5'($urandom);
      end
      if (!(stopAt != 0 && k == stopAt)) tick();
    end
  endtask

  // Fetch and decode a HALT, then confirm the unit stays halted with start high
  task automatic runHalt();
    checkOutput("halt IF", 64'(observed()),
                64'({2'd0, 2'd0, 5'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, modelIllegal}));
    opcode = 6'($urandom); func = 5'($urandom);
    tick();
    checkOutput("halt ID", 64'(observed()),
                64'({2'd0, 2'd0, 5'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, modelIllegal}));
    opcode = 6'b111111; func = 5'($urandom);
    tick();
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("halted c%0d", i), 64'(observed()), 64'(quietVec(1'b1, modelIllegal)));
      checkOutput($sformatf("halted count c%0d", i), 64'(instr_count), 64'(modelCount));
      opcode = 6'($urandom); func = 5'($urandom);
      tick();
    end
    start = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    modelCount   = '0;
    modelIllegal = 1'b0;
  endtask

  task automatic kickStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [5:0] op;
    int r;
    rst = 1'b1; start = 1'b0; opcode = '0; func = '0;
    doReset();

    // Idle with start low: nothing moves
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("idle c%0d", i), 64'(observed()), 64'(quietVec(1'b0, 1'b0)));
      checkOutput($sformatf("idle count c%0d", i), 64'(instr_count), 64'(modelCount));
      opcode = 6'($urandom); func = 5'($urandom);
      tick();
    end

    // Directed instructions, then a random stream long enough to wrap the counter
    kickStart();
    applyStimulus(6'd0, 5'b00010, 0);
    applyStimulus(6'd2, 5'($urandom), 0);
    applyStimulus(6'd3, 5'($urandom), 0);
    applyStimulus(6'd4, 5'($urandom), 0);
    applyStimulus(6'd6, 5'($urandom), 0);
    applyStimulus(6'd7, 5'($urandom), 0);
    applyStimulus(6'd5, 5'($urandom), 0);
    applyStimulus(6'd1, 5'b11010, 0);
    applyStimulus(6'd0, 5'b11111, 0);
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 8);
      op = (r < 8) ? 6'(r) : 6'($urandom_range(8, 62));
      applyStimulus(op, 5'($urandom), 0);
    end
    applyStimulus(6'd20, 5'($urandom), 0);
    runHalt();

    // Reset while a load sits in MEM: no writeback may follow
    doReset();
    kickStart();
    applyStimulus(6'd2, 5'($urandom), 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    modelCount = '0;
    modelIllegal = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("post-reset c%0d", i), 64'(observed()), 64'(quietVec(1'b0, 1'b0)));
      checkOutput($sformatf("post-reset count c%0d", i), 64'(instr_count), 64'(modelCount));
      tick();
    end

    // Normal operation resumes after the interrupted load
    kickStart();
    applyStimulus(6'd2, 5'($urandom), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
